// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one shared full-subtractor cell walks the operands LSB first,
// producing a - b - borrow_in over WIDTH cycles behind a start/ready/done handshake.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] sh_a_reg;
    logic [WIDTH-1:0] sh_b_reg;
    logic [WIDTH-1:0] sh_d_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [CW-1:0]    cnt_reg;
    logic             bw_reg;
    logic             bout_reg;
    logic             done_reg;
    logic             ready_reg;
    logic             busy_reg;

    // Full subtractor as two cascaded half subtractors; their borrows are ORed.
    logic             hs1_d;
    logic             hs1_b;
    logic             hs2_b;
    logic             d_bit;
    logic             bw_next;
    logic [WIDTH-1:0] sh_d_next;
    logic             last_bit;

    always_comb begin
        hs1_d     = sh_a_reg[0] ^ sh_b_reg[0];
        hs1_b     = ~sh_a_reg[0] & sh_b_reg[0];
        d_bit     = hs1_d ^ bw_reg;
        hs2_b     = ~hs1_d & bw_reg;
        bw_next   = hs1_b | hs2_b;
        sh_d_next = {d_bit, sh_d_reg[WIDTH-1:1]};
        last_bit  = (cnt_reg == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sh_a_reg  <= '0;
            sh_b_reg  <= '0;
            sh_d_reg  <= '0;
            diff_reg  <= '0;
            cnt_reg   <= '0;
            bw_reg    <= 1'b0;
            bout_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // abort is deliberately not looked at here; start always wins.
                    if (start) begin
                        sh_a_reg  <= a;
                        sh_b_reg  <= b;
                        bw_reg    <= borrow_in;
                        sh_d_reg  <= '0;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        sh_a_reg <= sh_a_reg >> 1;
                        sh_b_reg <= sh_b_reg >> 1;
                        sh_d_reg <= sh_d_next;
                        bw_reg   <= bw_next;
                        if (last_bit) begin
                            diff_reg  <= sh_d_next;
                            bout_reg  <= bw_next;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= DONE;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ready      = ready_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign difference = diff_reg;
    assign borrow_out = bout_reg;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: directed handshake scenarios plus randomized
// operations against an arithmetic reference of a - b - borrow_in.
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         borrow_in = 1'b0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] difference;
    logic         borrow_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_diff = '0;
    logic         exp_bout = 1'b0;

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .difference (difference),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    // Borrow of the full (W+1)-bit subtraction lands in the top bit.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic bi);
        return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for done after the accepting edge; reports edges taken and busy cycles seen.
    task automatic wait_done(output int edges, output int busy_n, output bit timeout);
        edges   = 0;
        busy_n  = busy ? 1 : 0;
        timeout = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            edges++;
            if (busy) busy_n++;
            if (done) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                          output int edges, output int busy_n, output bit timeout);
        a = x; b = y; borrow_in = bi; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(edges, busy_n, timeout);
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({ready, busy, done, difference, borrow_out} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
            n_err++;
            $display("FAIL reset: rdy/busy/done/diff/bout = %b/%b/%b/%h/%b, want 1/0/0/00/0",
                     ready, busy, done, difference, borrow_out);
        end
    endtask

    task automatic test_basic();
        int e, bn; bit to; logic [W:0] r;
        run_op(8'h05, 8'h03, 1'b0, e, bn, to);
        r = ref_sub(8'h05, 8'h03, 1'b0);
        $display("op basic a=05 b=03 -> diff=%h bout=%b edges=%0d", difference, borrow_out, e + 1);
        n_cmp++;
        if (to || (e + 1) !== W + 1) begin
            n_err++; $display("FAIL basic_latency: %0d edges (timeout=%0b), want %0d", e + 1, to, W + 1);
        end
        n_cmp++;
        if (bn !== W) begin n_err++; $display("FAIL basic_busy_cycles: %0d, want %0d", bn, W); end
        n_cmp++;
        if ({borrow_out, difference} !== r) begin
            n_err++; $display("FAIL basic_result: %b/%h, want %b/%h", borrow_out, difference, r[W], r[W-1:0]);
        end
        n_cmp++;
        if (ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_in_done: %b, want 0", ready); end
        step();
        n_cmp++;
        if ({done, ready} !== 2'b01) begin
            n_err++; $display("FAIL basic_after_done: done/ready=%b/%b, want 0/1", done, ready);
        end
        exp_diff = r[W-1:0]; exp_bout = r[W];
    endtask

    task automatic test_edge_values();
        logic [W-1:0] va [3] = '{8'h03, 8'h00, 8'hFF};
        logic [W-1:0] vb [3] = '{8'h05, 8'h00, 8'hFF};
        logic         vi [3] = '{1'b0, 1'b1, 1'b0};
        int e, bn; bit to; logic [W:0] r;
        for (int k = 0; k < 3; k++) begin
            run_op(va[k], vb[k], vi[k], e, bn, to);
            r = ref_sub(va[k], vb[k], vi[k]);
            $display("op edge a=%h b=%h bi=%b -> diff=%h bout=%b", va[k], vb[k], vi[k], difference, borrow_out);
            n_cmp++;
            if (to || {borrow_out, difference} !== r) begin
                n_err++; $display("FAIL edge_result_%0d: %b/%h (timeout=%0b), want %b/%h",
                                  k, borrow_out, difference, to, r[W], r[W-1:0]);
            end
            step();
            n_cmp++;
            if (done !== 1'b0) begin n_err++; $display("FAIL edge_single_done_%0d: done=%b, want 0", k, done); end
            exp_diff = r[W-1:0]; exp_bout = r[W];
        end
    endtask

    task automatic test_ignore_start();
        int e, bn; bit to; logic [W:0] r;
        a = 8'h80; b = 8'h01; borrow_in = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        a = 8'h11; b = 8'h11; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(e, bn, to);
        r = ref_sub(8'h80, 8'h01, 1'b0);
        $display("op ignore a=80 b=01 -> diff=%h bout=%b", difference, borrow_out);
        n_cmp++;
        if (to || (e + 3) !== W || {borrow_out, difference} !== r) begin
            n_err++; $display("FAIL ignore_start: %b/%h after %0d edges (timeout=%0b), want %b/%h after %0d",
                              borrow_out, difference, e + 3, to, r[W], r[W-1:0], W);
        end
        a = 8'h20; b = 8'h01; borrow_in = 1'b1; start = 1'b1;
        step();
        n_cmp++;
        if ({ready, busy} !== 2'b10) begin
            n_err++; $display("FAIL held_start_done_edge: ready/busy=%b/%b, want 1/0", ready, busy);
        end
        step();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL held_start_accept: busy=%b, want 1", busy); end
        wait_done(e, bn, to);
        r = ref_sub(8'h20, 8'h01, 1'b1);
        $display("op held a=20 b=01 bi=1 -> diff=%h bout=%b", difference, borrow_out);
        n_cmp++;
        if (to || {borrow_out, difference} !== r) begin
            n_err++; $display("FAIL held_start_result: %b/%h, want %b/%h", borrow_out, difference, r[W], r[W-1:0]);
        end
        step();
        exp_diff = r[W-1:0]; exp_bout = r[W];
    endtask

    task automatic test_abort();
        int e, bn, dn; bit to; logic [W:0] r;
        run_op(8'h05, 8'h03, 1'b0, e, bn, to);
        step();
        r = ref_sub(8'h05, 8'h03, 1'b0);
        exp_diff = r[W-1:0]; exp_bout = r[W];
        a = 8'h10; b = 8'h01; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        $display("op abort a=10 b=01 aborted in RUN -> diff=%h", difference);
        n_cmp++;
        if ({ready, busy, done} !== 3'b100) begin
            n_err++; $display("FAIL abort_idle: ready/busy/done=%b/%b/%b, want 1/0/0", ready, busy, done);
        end
        dn = 0;
        for (int i = 0; i < W + 2; i++) begin
            step();
            if (done) dn++;
        end
        n_cmp++;
        if (dn !== 0 || difference !== exp_diff || borrow_out !== exp_bout) begin
            n_err++; $display("FAIL abort_hold: dones=%0d diff=%h bout=%b, want 0/%h/%b",
                              dn, difference, borrow_out, exp_diff, exp_bout);
        end
        a = 8'h33; b = 8'h11; start = 1'b1;
        step();
        start = 1'b0;
        repeat (W - 1) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        $display("op abort a=33 b=11 aborted on last bit -> diff=%h", difference);
        n_cmp++;
        if (done !== 1'b0 || ready !== 1'b1 || difference !== exp_diff) begin
            n_err++; $display("FAIL abort_last_bit: done/ready/diff=%b/%b/%h, want 0/1/%h",
                              done, ready, difference, exp_diff);
        end
        a = 8'h09; b = 8'h04; borrow_in = 1'b0; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL idle_start_abort: busy=%b, want 1", busy); end
        wait_done(e, bn, to);
        r = ref_sub(8'h09, 8'h04, 1'b0);
        $display("op start+abort a=09 b=04 -> diff=%h bout=%b", difference, borrow_out);
        n_cmp++;
        if (to || {borrow_out, difference} !== r) begin
            n_err++; $display("FAIL idle_start_abort_result: %b/%h, want %b/%h", borrow_out, difference, r[W], r[W-1:0]);
        end
        step();
        exp_diff = r[W-1:0]; exp_bout = r[W];
    endtask

    task automatic test_async_reset();
        int e, bn; bit to; logic [W:0] r;
        a = 8'hF0; b = 8'h01; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        $display("op async reset mid-RUN -> ready=%b diff=%h", ready, difference);
        n_cmp++;
        if ({ready, busy, done, difference, borrow_out} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
            n_err++; $display("FAIL async_reset: rdy/busy/done/diff/bout = %b/%b/%b/%h/%b, want 1/0/0/00/0",
                              ready, busy, done, difference, borrow_out);
        end
        #2 rst_n = 1'b1;
        step();
        run_op(8'h0A, 8'h04, 1'b0, e, bn, to);
        r = ref_sub(8'h0A, 8'h04, 1'b0);
        $display("op post-reset a=0a b=04 -> diff=%h bout=%b", difference, borrow_out);
        n_cmp++;
        if (to || {borrow_out, difference} !== r) begin
            n_err++; $display("FAIL post_reset_result: %b/%h, want %b/%h", borrow_out, difference, r[W], r[W-1:0]);
        end
        step();
        exp_diff = r[W-1:0]; exp_bout = r[W];
    endtask

    task automatic test_random();
        int total_dones = 0;
        int n_ok = 0;
        logic [W-1:0] xa, xb; logic xi; logic [W:0] r;
        int abort_at, dn; bit aborted;
        for (int op = 0; op < 200; op++) begin
            repeat ($urandom_range(0, 2)) step();
            xa = W'($urandom); xb = W'($urandom); xi = 1'($urandom);
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
            a = xa; b = xb; borrow_in = xi; start = 1'b1;
            step();
            start = 1'b0;
            n_cmp++;
            if (busy !== 1'b1) begin n_err++; $display("FAIL rand_accept_%0d: busy=%b, want 1", op, busy); end
            aborted = 1'b0;
            dn = 0;
            for (int c = 1; c <= W; c++) begin
                abort = (c == abort_at);
                start = 1'($urandom);
                a = W'($urandom); b = W'($urandom);
                step();
                if (done) dn++;
                if (c == abort_at) begin
                    aborted = 1'b1;
                    break;
                end
            end
            start = 1'b0; abort = 1'b0;
            if (aborted) begin
                $display("op rand %0d a=%h b=%h bi=%b aborted at %0d", op, xa, xb, xi, abort_at);
                n_cmp++;
                if (dn !== 0 || ready !== 1'b1 || difference !== exp_diff || borrow_out !== exp_bout) begin
                    n_err++; $display("FAIL rand_abort_%0d: dones=%0d ready=%b diff=%h bout=%b, want 0/1/%h/%b",
                                      op, dn, ready, difference, borrow_out, exp_diff, exp_bout);
                end
            end else begin
                r = ref_sub(xa, xb, xi);
                n_ok++;
                $display("op rand %0d a=%h b=%h bi=%b -> diff=%h bout=%b", op, xa, xb, xi, difference, borrow_out);
                n_cmp++;
                if (dn !== 1 || {borrow_out, difference} !== r) begin
                    n_err++; $display("FAIL rand_result_%0d: dones=%0d %b/%h, want 1 %b/%h",
                                      op, dn, borrow_out, difference, r[W], r[W-1:0]);
                end
                exp_diff = r[W-1:0]; exp_bout = r[W];
                step();
                if (done) dn++;
            end
            total_dones += dn;
        end
        n_cmp++;
        if (total_dones !== n_ok) begin
            n_err++; $display("FAIL rand_done_count: %0d, want %0d", total_dones, n_ok);
        end
    endtask

    initial begin
        #12 rst_n = 1'b1;
        step();
        test_reset();
        test_basic();
        test_edge_values();
        test_ignore_start();
        test_abort();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial multi-bit subtractor controller. It sequences a single shared 1-bit subtractor cell over WIDTH cycles, LSB first, to compute a - b - borrow_in. The cell is a full subtractor built from two half subtractors plus an OR. Used where area matters more than latency; a start/ready/done handshake lets a host FSM issue operations back to back.

Parameters:
WIDTH, 8, operand and result width in bits (must be >= 2).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a new operation; accepted only when ready=1.
abort  input  1  synchronous cancel of an in-flight operation.
a  input  WIDTH  minuend, sampled on the accepting edge.
b  input  WIDTH  subtrahend, sampled on the accepting edge.
borrow_in  input  1  initial borrow, sampled on the accepting edge.
ready  output  1  high in IDLE only.
busy  output  1  high in RUN only.
done  output  1  one-cycle pulse: result registers just updated.
difference  output  WIDTH  registered result, held until the next completion.
borrow_out  output  1  final borrow (1 = a < b + borrow_in), held with difference.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, ready=1, busy=0, done=0, difference=0, borrow_out=0. All internal shift registers, the borrow flop and the counter clear.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - start=1 at a clock edge (edge E0): load sh_a<=a, sh_b<=b, bw<=borrow_in, sh_d<=0, cnt<=0, then go to RUN.
  - abort is ignored in IDLE.
- RUN, one bit per edge, using bit 0 of sh_a and sh_b:
  - d = a0 ^ b0 ^ bw
  - bw_next = (~a0 & b0) | (~(a0 ^ b0) & bw)
  - sh_a and sh_b shift right; sh_d shifts right with d entering at the MSB; cnt increments.
  - Edges E1..E_WIDTH process bits 0..WIDTH-1.
  - At edge E_WIDTH (cnt = WIDTH-1 before the edge): difference<=final sh_d, borrow_out<=bw_next, done<=1, then go to DONE.
- DONE lasts exactly one cycle: done=1, ready=0. The next edge returns to IDLE and done drops to 0.
- Latency: start accepted at E0 -> done high for the cycle after E_WIDTH. Minimum issue interval is WIDTH+2 edges.
- start while RUN or DONE is ignored; nothing is queued. A start held high through DONE is accepted on the first IDLE edge.
- abort=1 in RUN: go to IDLE at the next edge. No done pulse. difference and borrow_out keep their previous values. abort has priority over the final-bit update at E_WIDTH.
- abort and start both high in IDLE: start is accepted.
- difference and borrow_out change only on the edge that asserts done. They stay stable throughout RUN.
- Arithmetic is modulo 2^WIDTH. borrow_out equals the borrow of the full WIDTH+1-bit subtraction. There are no overflow or sign flags.
- rst_n asserted mid-RUN: immediate return to reset values. The partial result is discarded.
- Counter width is $clog2(WIDTH). Comparison is against WIDTH-1, with no wrap beyond it.

Test Plan:
All scenarios use WIDTH=8.
1. a=0x05, b=0x03, bw_in=0, start 1 cycle -> busy for 8 cycles; done pulses once 9 edges after start; difference=0x02, borrow_out=0; ready returns the cycle after done.
2. a=0x03, b=0x05, bw_in=0 -> difference=0xFE, borrow_out=1. Then a=0x00, b=0x00, bw_in=1 -> difference=0xFF, borrow_out=1. Then a=0xFF, b=0xFF -> difference=0x00, borrow_out=0.
3. Start 0x80-0x01, then pulse start with a=0x11, b=0x11 at cycle 3 of RUN -> second request ignored; result 0x7F, borrow_out=0. Holding start high through DONE -> new op accepted the cycle after DONE.
4. Complete 0x05-0x03, then start 0x10-0x01 and assert abort at RUN cycle 4 -> IDLE next edge, no done, difference stays 0x02.
5. Assert rst_n=0 asynchronously mid-RUN between edges -> outputs zero immediately, ready=1. After release, 0x0A-0x04 -> 0x06, borrow_out=0.
6. Random 200 operations with random abort/start timing, checked against a reference model (a - b - bw_in) mod 256 with borrow -> full match; exactly one done per non-aborted op.
